// File: rtl/div_rem_unit.sv
// div_rem_unit: iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish in one cycle; all others take XLEN+1.
module div_rem_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t          state;
    logic [1:0]      op_q;
    logic            sgn1, sgn2;
    logic [XLEN-1:0] dvs, quo;
    logic [XLEN:0]   rem;
    logic [CW-1:0]   count;
    logic            signed_op, ovf, ge;
    logic [XLEN-1:0] abs1, abs2, quo_fix, rem_fix;
    logic [XLEN:0]   rem_sh;
    always_comb begin
        signed_op = ~op[0];
        abs1      = (signed_op && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2      = (signed_op && rs2[XLEN-1]) ? -rs2 : rs2;
        ovf       = signed_op && rs1 == {1'b1, {(XLEN-1){1'b0}}} && (&rs2);
        rem_sh    = {rem[XLEN-1:0], quo[XLEN-1]};
        ge        = rem_sh >= {1'b0, dvs};
        quo_fix   = (~op_q[0] && (sgn1 ^ sgn2)) ? -quo : quo;
        rem_fix   = (~op_q[0] && sgn1) ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_q   <= '0;
            sgn1   <= 1'b0;
            sgn2   <= 1'b0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
            count  <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (flush) state <= IDLE;
            else case (state)
                IDLE: if (start) begin
                    if (rs2 == '0) begin
                        result <= op[1] ? rs1 : '1;
                        done   <= 1'b1;
                    end else if (ovf) begin
                        result <= op[1] ? '0 : rs1;
                        done   <= 1'b1;
                    end else begin
                        op_q  <= op;
                        sgn1  <= signed_op & rs1[XLEN-1];
                        sgn2  <= signed_op & rs2[XLEN-1];
                        dvs   <= abs2;
                        rem   <= '0;
                        quo   <= abs1;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem   <= ge ? rem_sh - {1'b0, dvs} : rem_sh;
                    quo   <= {quo[XLEN-2:0], ge};
                    count <= count + CW'(1);
                    state <= count == CW'(XLEN - 1) ? FIX : CALC;
                end
                FIX: begin
                    result <= op_q[1] ? rem_fix : quo_fix;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_rem_unit.sv
// tb_div_rem_unit: table vectors, corner sequences and random ops vs an arithmetic model.
module tb_div_rem_unit;
    localparam int NORM = 33;
    localparam int SPEC = 0;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    int checks = 0;
    int errors = 0;

    div_rem_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1; r = a;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0;
        end else if (!o[0]) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    // lat = rising edges after the one that sampled start; bcnt = busy samples before done
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt, output logic bsy_done);
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = result;
        bsy_done = busy;
    endtask

    initial begin
        logic [31:0] res, prev, a, b;
        logic [1:0]  o;
        int lat, bcnt;
        logic bd, seen;
        vecs[0]  = '{2'b00, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, NORM};
        vecs[1]  = '{2'b10, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, NORM};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, NORM};
        vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, NORM};
        vecs[4]  = '{2'b00, 32'h1234,      32'h0,        32'hFFFF_FFFF, SPEC};
        vecs[5]  = '{2'b01, 32'h1234,      32'h0,        32'hFFFF_FFFF, SPEC};
        vecs[6]  = '{2'b10, 32'h1234,      32'h0,        32'h0000_1234, SPEC};
        vecs[7]  = '{2'b11, 32'h1234,      32'h0,        32'h0000_1234, SPEC};
        vecs[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC};
        vecs[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SPEC};
        vecs[10] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         NORM};
        vecs[11] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORM};
        vecs[12] = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM};
        vecs[13] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h1,         NORM};
        vecs[14] = '{2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h3,         NORM};
        vecs[15] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, NORM};

        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt, bd);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].lat == NORM ? 33 : 0);
            check($sformatf("vec%0d_busy_at_done", i), {31'b0, bd}, 32'h0);
        end

        @(negedge clk);
        check("done_pulse_width", {31'b0, done}, 32'h0);
        prev = result;
        start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_drop", {31'b0, busy}, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush_no_done", {31'b0, seen}, 32'h0);
        check("flush_result_held", result, prev);
        run(2'b01, 32'd50, 32'd5, res, lat, bcnt, bd);
        check("after_flush_result", res, 32'd10);

        start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd10;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            start = lat == 5;
            op = 2'b10; rs1 = 32'd77; rs2 = 32'd0;
        end
        start = 1'b0;
        check("ignored_start_latency", lat, NORM);
        check("ignored_start_result", result, 32'd100);

        start = 1'b1; op = 2'b10; rs1 = 32'h55; rs2 = 32'h0;
        @(negedge clk);
        check("b2b_special_done", {31'b0, done}, 32'h1);
        check("b2b_special_result", result, 32'h55);
        start = 1'b1; op = 2'b01; rs1 = 32'd50; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_normal_latency", lat, NORM);
        check("b2b_normal_result", result, 32'd10);

        @(negedge clk);
        start = 1'b1; op = 2'b00; rs1 = 32'd1000; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_reset_busy", {31'b0, busy}, 32'h0);
        check("async_reset_done", {31'b0, done}, 32'h0);
        check("async_reset_result", result, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rst = 1'b1;
        check("reset_no_done", {31'b0, seen}, 32'h0);

        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2, 3: b = $urandom_range(1, 40);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run(o, a, b, res, lat, bcnt, bd);
            check($sformatf("rand%0d_op%0d_%08h_%08h", i, o, a, b), res, model(o, a, b));
            check($sformatf("rand%0d_latency", i), lat,
                  (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? SPEC : NORM);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
